// File: rtl/regfile_mp.sv
// Multi-port register file: forwarding reads, per-register busy scoreboard, post-reset clear FSM.
// Optional commit trace output enabled by defining REGFILE_MP_COMMIT_TRACE_EN.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR     = 2,
    parameter int NW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NR*ADDR_W-1:0] I_raddr,
    output logic [NR*DATA_W-1:0] O_rdata,
    output logic [NR-1:0]        O_rbusy,
    input  logic [NW-1:0]        I_we,
    input  logic [NW*ADDR_W-1:0] I_waddr,
    input  logic [NW*DATA_W-1:0] I_wdata,
    input  logic                 I_iss_valid,
    input  logic [ADDR_W-1:0]    I_iss_rd,
    input  logic                 I_flush,
    output logic                 O_ready,
    output logic [NW-1:0]        O_trc_valid,
    output logic [NW*ADDR_W-1:0] O_trc_addr,
    output logic [NW*DATA_W-1:0] O_trc_data
);

    localparam int REG_NUM = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                ready_q;
    logic [REG_NUM-1:0]  busy_q;
    logic [REG_NUM-1:0]  busy_d;
    logic [DATA_W-1:0]   regs_q [REG_NUM];

    logic [ADDR_W-1:0]   waddr_w [NW];
    logic [DATA_W-1:0]   wdata_w [NW];
    logic [ADDR_W-1:0]   raddr_w [NR];
    logic [NW-1:0]       wr_ok;
    logic                run;

    assign run = (state_q == ST_READY);

    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_wport
            assign waddr_w[gi] = I_waddr[gi*ADDR_W +: ADDR_W];
            assign wdata_w[gi] = I_wdata[gi*DATA_W +: DATA_W];
            // A write only counts once the file is cleared and never targets x0.
            assign wr_ok[gi]   = run && I_we[gi] && (waddr_w[gi] != '0);
        end
        for (gi = 0; gi < NR; gi++) begin : g_raddr
            assign raddr_w[gi] = I_raddr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Clear sequencer: walks x1..x(REG_NUM-1), then holds READY until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_FIRST;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign O_ready = ready_q;

    // Storage has no reset so it can map onto RAM; later ports overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_ok[j]) begin
                    regs_q[waddr_w[j]] <= wdata_w[j];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NR; gi++) begin : g_rport
            logic              fwd_hit;
            logic [DATA_W-1:0] fwd_data;
            logic [DATA_W-1:0] rd_val;

            always_comb begin
                fwd_hit  = 1'b0;
                fwd_data = '0;
                for (int j = 0; j < NW; j++) begin
                    if (wr_ok[j] && (waddr_w[j] == raddr_w[gi])) begin
                        fwd_hit  = 1'b1;
                        fwd_data = wdata_w[j];
                    end
                end
            end

            always_comb begin
                rd_val = '0;
                if (run && (raddr_w[gi] != '0)) begin
                    rd_val = fwd_hit ? fwd_data : regs_q[raddr_w[gi]];
                end
            end

            assign O_rdata[gi*DATA_W +: DATA_W] = rd_val;
            // Forwarded data is already current, so a same-cycle writeback hides busy.
            assign O_rbusy[gi] = run && busy_q[raddr_w[gi]] && !fwd_hit &&
                                 (raddr_w[gi] != '0);
        end
    endgenerate

    assign busy_d[0] = 1'b0;

    generate
        for (gi = 1; gi < REG_NUM; gi++) begin : g_busy
            logic sb_set;
            logic sb_clr;

            assign sb_set = I_iss_valid && (I_iss_rd == ADDR_W'(gi));

            always_comb begin
                sb_clr = 1'b0;
                for (int j = 0; j < NW; j++) begin
                    if (I_we[j] && (waddr_w[j] == ADDR_W'(gi))) begin
                        sb_clr = 1'b1;
                    end
                end
            end

            // A new producer issued alongside a writeback keeps the register busy.
            assign busy_d[gi] = I_flush ? 1'b0 : (sb_set | (busy_q[gi] & ~sb_clr));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (run) begin
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_MP_COMMIT_TRACE_EN
    logic [NW-1:0]        acc_w;
    logic [NW-1:0]        trc_valid_q;
    logic [NW*ADDR_W-1:0] trc_addr_q;
    logic [NW*DATA_W-1:0] trc_data_q;

    generate
        for (gi = 0; gi < NW; gi++) begin : g_trc_acc
            logic acc;

            always_comb begin
                acc = wr_ok[gi];
                for (int jj = gi + 1; jj < NW; jj++) begin
                    if (wr_ok[jj] && (waddr_w[jj] == waddr_w[gi])) begin
                        acc = 1'b0;
                    end
                end
            end

            assign acc_w[gi] = acc;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trc_valid_q <= '0;
            trc_addr_q  <= '0;
            trc_data_q  <= '0;
        end else begin
            trc_valid_q <= acc_w;
            for (int j = 0; j < NW; j++) begin
                trc_addr_q[j*ADDR_W +: ADDR_W] <= acc_w[j] ? waddr_w[j] : '0;
                trc_data_q[j*DATA_W +: DATA_W] <= acc_w[j] ? wdata_w[j] : '0;
            end
        end
    end

    assign O_trc_valid = trc_valid_q;
    assign O_trc_addr  = trc_addr_q;
    assign O_trc_data  = trc_data_q;
`else
    assign O_trc_valid = '0;
    assign O_trc_addr  = '0;
    assign O_trc_data  = '0;
`endif

endmodule
